// File: rtl/updown_pkg.sv
// Shared types, default parameters and the shortest-path direction rule
// for the up/down counter press driver.
package updown_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_HOLD_CYCLES = 2;
    localparam int DEF_GAP_CYCLES  = 2;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP,
        FINISH
    } state_t;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_t;

    // Shortest path modulo 2^width; an exact half-turn tie resolves to UP.
    function automatic dir_t calc_dir(input logic [31:0] tgt,
                                      input logic [31:0] mirror,
                                      input int unsigned width);
        logic [31:0] mask;
        logic [31:0] diff;
        logic [31:0] half;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        diff = (tgt - mirror) & mask;
        half = 32'd1 << (width - 1);
        return (diff <= half) ? DIR_UP : DIR_DOWN;
    endfunction

endpackage

// File: rtl/updown_phase_timer.sv
// Loadable down-counter; expire is high while the count sits at zero,
// marking the last cycle of a PRESS or GAP phase.
module updown_phase_timer #(
    parameter int TW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          en,
    output logic          expire
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // NOTE: cnt_d gets a default before any branch so the block cannot infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/updown_driver.sv
// Press-sequence generator: walks a mirrored up/down counter to a target
// value with discrete, gap-separated button presses along the shortest path.
module updown_driver
    import updown_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    output logic             up,
    output logic             down,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] mirror
);

    localparam int MAX_PHASE = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW        = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

    state_t           state_q, state_d;
    dir_t             dir_q, dir_d;
    dir_t             new_dir;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] mirror_q, mirror_d;
    logic             up_q, up_d;
    logic             down_q, down_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             tmr_load;
    logic [TW-1:0]    tmr_load_val;
    logic             tmr_en;
    logic             tmr_expire;

    updown_phase_timer #(
        .TW (TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        tgt_d        = tgt_q;
        mirror_d     = mirror_q;
        up_d         = up_q;
        down_d       = down_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = HOLD_LOAD;
        tmr_en       = 1'b0;
        new_dir      = calc_dir(32'(target), 32'(mirror_q), WIDTH);

        // busy stays up through the done cycle and drops on the one after
        if (done_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    tgt_d  = target;
                    busy_d = 1'b1;
                    if (target == mirror_q) begin
                        state_d = FINISH;
                    end else begin
                        dir_d    = new_dir;
                        up_d     = (new_dir == DIR_UP);
                        down_d   = (new_dir == DIR_DOWN);
                        tmr_load = 1'b1;
                        state_d  = PRESS;
                    end
                end
            end
            PRESS: begin
                tmr_en = 1'b1;
                if (tmr_expire) begin
                    up_d         = 1'b0;
                    down_d       = 1'b0;
                    mirror_d     = (dir_q == DIR_UP) ? mirror_q + WIDTH'(1)
                                                     : mirror_q - WIDTH'(1);
                    tmr_load     = 1'b1;
                    tmr_load_val = GAP_LOAD;
                    state_d      = GAP;
                end
            end
            GAP: begin
                tmr_en = 1'b1;
                if (tmr_expire) begin
                    if (mirror_q == tgt_q) begin
                        state_d = FINISH;
                    end else begin
                        up_d     = (dir_q == DIR_UP);
                        down_d   = (dir_q == DIR_DOWN);
                        tmr_load = 1'b1;
                        state_d  = PRESS;
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            dir_q    <= DIR_UP;
            tgt_q    <= '0;
            mirror_q <= '0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            tgt_q    <= tgt_d;
            mirror_q <= mirror_d;
            up_q     <= up_d;
            down_q   <= down_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign up     = up_q;
    assign down   = down_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign mirror = mirror_q;

endmodule

// File: doc/updown_driver.md
Name: updown_driver

Overview:
Press-sequence generator that drives the up/down button inputs of the team's 8-bit up/down counter FSM. Given a target value, it emits discrete press/release pulses on up or down to move the counter there. It takes the shortest path modulo 2^WIDTH. It keeps a mirror of the counter value so it needs no feedback, and sits between control logic (or a testbench sequencer) and the counter.

Parameters:
WIDTH, 8, counter width; must match the driven counter.
HOLD_CYCLES, 2, cycles each press is held high (>=1).
GAP_CYCLES, 2, cycles both lines are held low between presses (>=1); this releases the counter's pressed latch.

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high
start  input  1  request; sampled only in IDLE
target  input  WIDTH  requested counter value; latched when start is accepted
up  output  1  registered up-button line to counter
down  output  1  registered down-button line to counter
busy  output  1  high while a request is in progress
done  output  1  one-cycle pulse when the request completes
mirror  output  WIDTH  driver's copy of the counter value

Behaviour:
- Reset values: up=0, down=0, busy=0, done=0, mirror=0, state=IDLE. This matches the counter's reset value of 0. Reset mid-operation aborts immediately: outputs take reset values at the next edge and no further presses are issued.
- States: IDLE, PRESS, GAP, FINISH.
- IDLE:
  - On start=1: latch target into tgt and set busy=1.
  - If tgt==mirror, go to FINISH.
  - Otherwise compute dir and go to PRESS with the selected line asserted from the next cycle.
- Direction rule: diff = (tgt - mirror) mod 2^WIDTH.
  - diff < 2^(WIDTH-1): dir=UP.
  - diff > 2^(WIDTH-1): dir=DOWN.
  - diff == 2^(WIDTH-1): tie, dir=UP.
  - dir is fixed for the whole request.
- PRESS: exactly one of up/down is high, per dir, for HOLD_CYCLES consecutive cycles.
  - On the last hold cycle, mirror updates by +1 (UP) or -1 (DOWN), with WIDTH-bit wrap (255+1=0, 0-1=255).
  - Then go to GAP.
- GAP: up=down=0 for GAP_CYCLES cycles. Then, if mirror==tgt, go to FINISH; otherwise go to PRESS.
- FINISH: done=1 for one cycle, busy=0 from the following cycle, return to IDLE.
- up and down are never high simultaneously.
- up/down never toggle without an intervening low period of >= GAP_CYCLES.
- Press count: a request with shortest distance n issues exactly n presses.
- Latency: with n>0, done asserts n*(HOLD_CYCLES+GAP_CYCLES)+1 cycles after the start-accept edge. With n=0, done asserts 1 cycle after accept.
- start while busy: ignored, not queued.
- start held high across FINISH: the new request is accepted on the first IDLE cycle.
- target changes while busy: no effect; the latched tgt is used.

Decomposition:
- Package updown_pkg:
  - state enum state_t {IDLE, PRESS, GAP, FINISH}.
  - dir_t {DIR_UP, DIR_DOWN}.
  - Default WIDTH/HOLD/GAP localparams.
  - A function computing dir from (tgt, mirror).
- One sub-module, updown_phase_timer:
  - Loadable down-counter that generates the end-of-phase strobe for PRESS and GAP.
  - Inputs: load value, load, enable. Output: expire.
- FSM, mirror register and output registers live in updown_driver.

Test Plan:
- Bench connects fsm_UD to up/down and checks that its counter equals mirror at every done.
- Reset for 3 cycles -> up=down=busy=done=0, mirror=0.
- From 0, start with target=3 -> 3 up pulses, each 2 cycles high with 2-cycle gaps; done at cycle 13 after accept; mirror=3; counter=3.
- From 3, target=1 -> 2 down pulses, no up; mirror=1; counter=1.
- From 0, target=255 -> exactly 1 down pulse (wrap); mirror=255; counter=255.
- From 0, target=128 (tie) -> 128 up pulses; mirror=128. Start pulsed during the run is ignored (exactly 128 presses).
- target==mirror (5) -> no pulses, done 1 cycle after accept.
- Reset asserted mid-PRESS of target=10 request -> up=0 next cycle, mirror=0, busy=0, no further pulses.
